// File: rtl/keypad_fifo_reader.sv
// Keypad handshake initiator: polls status, fetches and acks key codes into a FIFO,
// and exposes the FIFO to the CPU as a STATUS/DATA register pair plus a 4-digit history.
module keypad_fifo_reader #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        kp_statusordata,
    output logic        kp_ack,
    input  logic [3:0]  kp_keyout,
    input  logic        cpu_sel,
    input  logic        cpu_rd,
    output logic [15:0] cpu_rdata,
    output logic [15:0] digits
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        POLL   = 2'd0,
        FETCH  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    mem_q [DEPTH];

    logic          push;
    logic          pop;
    logic          data_rd;
    logic          empty;
    logic [4:0]    count5;

    always_comb begin
        state_d         = state_q;
        kp_statusordata = 1'b1;
        kp_ack          = 1'b0;
        case (state_q)
            POLL: begin
                // Full check uses the pre-edge count, so a same-cycle pop only unblocks next cycle.
                if (kp_keyout[0] && (count_q < DEPTH_C)) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                kp_statusordata = 1'b0;
                kp_ack          = 1'b1;
                state_d         = SETTLE;
            end
            SETTLE: begin
                state_d = POLL;
            end
            default: begin
                state_d = POLL;
            end
        endcase
    end

    assign push    = (state_q == FETCH);
    assign data_rd = cpu_rd & ~cpu_sel;
    assign empty   = (count_q == '0);
    assign pop     = data_rd & ~empty;

    always_comb begin
        wptr_d      = wptr_q + PW'(push);
        rptr_d      = rptr_q + PW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        underflow_d = underflow_q;
        digits_d    = digits_q;
        if (data_rd && empty) begin
            underflow_d = 1'b1;
        end else if (cpu_rd && cpu_sel) begin
            underflow_d = 1'b0;
        end
        if (push) begin
            digits_d = {digits_q[11:0], kp_keyout};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= POLL;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            digits_q    <= digits_d;
        end
    end

    // Storage is only observable through count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= kp_keyout;
        end
    end

    assign count5 = 5'(count_q);

    always_comb begin
        cpu_rdata = 16'h0000;
        if (cpu_sel) begin
            cpu_rdata = {8'h00, underflow_q, 2'b00, count5};
        end else if (!empty) begin
            cpu_rdata = {12'h000, mem_q[rptr_q]};
        end
    end

    assign digits = digits_q;

endmodule

// File: tb/tb_keypad_fifo_reader.sv
// Directed bench for keypad_fifo_reader: a keypad model feeds key codes, a scoreboard
// queue holds expected CPU read data, and a negedge monitor checks reads and ack rules.
module tb_keypad_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kp_statusordata;
    logic        kp_ack;
    logic [3:0]  kp_keyout;
    logic        cpu_sel = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [15:0] cpu_rdata;
    logic [15:0] digits;

    int          tests = 0;
    int          fails = 0;
    int          ack_cnt = 0;
    logic        ack_prev = 1'b0;
    logic [15:0] sb_q [$];
    logic [3:0]  kq [$];
    logic        kp_avail = 1'b0;
    logic [3:0]  kp_code = 4'h0;

    keypad_fifo_reader #(.DEPTH(4), .CW(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .kp_statusordata (kp_statusordata),
        .kp_ack          (kp_ack),
        .kp_keyout       (kp_keyout),
        .cpu_sel         (cpu_sel),
        .cpu_rd          (cpu_rd),
        .cpu_rdata       (cpu_rdata),
        .digits          (digits)
    );

    always #5 clk = ~clk;

    assign kp_keyout = kp_statusordata ? {3'b000, kp_avail} : kp_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, input logic [15:0] exp);
        cpu_sel = sel;
        cpu_rd  = 1'b1;
        sb_q.push_back(exp);
        tick();
        cpu_rd  = 1'b0;
    endtask

    task automatic peek(input logic sel, input logic [15:0] exp, input string name);
        cpu_sel = sel;
        #1;
        check(name, {16'h0, cpu_rdata}, {16'h0, exp});
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int n = 0;
        while (ack_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, ack_cnt, target);
    endtask

    // Keypad model: holds a queue of pending keys; an ack consumes the head.
    initial begin
        forever begin
            @(posedge clk);
            if (kp_ack && kq.size() != 0) void'(kq.pop_front());
            kp_avail <= (kq.size() != 0);
            kp_code  <= (kq.size() != 0) ? kq[0] : 4'h0;
        end
    end

    // Monitor: ack protocol rules and scoreboard comparison of every CPU read.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (kp_ack) begin
                    ack_cnt++;
                    check("ack_status_mode", {31'b0, kp_statusordata}, 32'd0);
                    check("ack_back_to_back", {31'b0, ack_prev}, 32'd0);
                end
                ack_prev = kp_ack;
                if (cpu_rd) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_read: got %0h expected no read", cpu_rdata);
                    end else begin
                        check(cpu_sel ? "status_read" : "data_read", {16'h0, cpu_rdata},
                              {16'h0, sb_q.pop_front()});
                    end
                end
            end else begin
                ack_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) tick();
        peek(1'b0, 16'h0000, "reset_data");
        peek(1'b1, 16'h0000, "reset_status");
        check("reset_statusordata", {31'b0, kp_statusordata}, 32'd1);
        check("reset_ack", {31'b0, kp_ack}, 32'd0);
        check("reset_digits", {16'h0, digits}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single key
        kq.push_back(4'h7);
        wait_acks(1, 10, "single_ack");
        rd(1'b1, 16'h0001);
        rd(1'b0, 16'h0007);
        rd(1'b1, 16'h0000);
        check("single_digits", {16'h0, digits}, 32'h0007);

        // Fill and backpressure
        for (int i = 1; i <= 5; i++) kq.push_back(4'(i));
        wait_acks(5, 40, "fill_acks");
        repeat (8) tick();
        check("backpressure_acks", ack_cnt, 5);
        rd(1'b1, 16'h0004);
        check("fill_digits", {16'h0, digits}, 32'h1234);
        rd(1'b0, 16'h0001);
        wait_acks(6, 3, "resume_ack");
        check("fifth_digits", {16'h0, digits}, 32'h2345);
        rd(1'b0, 16'h0002);
        rd(1'b0, 16'h0003);
        rd(1'b0, 16'h0004);
        rd(1'b0, 16'h0005);
        rd(1'b1, 16'h0000);

        // Wrap-around
        for (int i = 0; i < 10; i++) begin
            kq.push_back(4'(i));
            wait_acks(7 + i, 10, "wrap_ack");
            rd(1'b0, 16'(i));
        end
        rd(1'b1, 16'h0000);
        check("wrap_digits", {16'h0, digits}, 32'h6789);

        // Underflow
        rd(1'b0, 16'h0000);
        rd(1'b1, 16'h0080);
        rd(1'b1, 16'h0000);

        // Simultaneous push and pop at count 2
        kq.push_back(4'hA);
        kq.push_back(4'hB);
        wait_acks(18, 20, "sim_fill_acks");
        rd(1'b1, 16'h0002);
        kq.push_back(4'hC);
        n = 0;
        while (!kp_ack && n < 10) begin
            tick();
            n++;
        end
        check("sim_fetch_seen", {31'b0, kp_ack}, 32'd1);
        if (kp_ack) rd(1'b0, 16'h000A);
        rd(1'b1, 16'h0002);
        check("sim_digits", {16'h0, digits}, 32'h9ABC);
        check("sim_acks", ack_cnt, 19);
        rd(1'b0, 16'h000B);
        rd(1'b0, 16'h000C);
        rd(1'b1, 16'h0000);

        // Reset during FETCH
        kq.push_back(4'h3);
        n = 0;
        while (!kp_ack && n < 10) begin
            tick();
            n++;
        end
        check("rst_fetch_seen", {31'b0, kp_ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {31'b0, kp_ack}, 32'd0);
        check("rst_mid_statusordata", {31'b0, kp_statusordata}, 32'd1);
        check("rst_mid_digits", {16'h0, digits}, 32'h0);
        peek(1'b1, 16'h0000, "rst_mid_status");
        tick();
        tick();
        rst_n = 1'b1;
        wait_acks(20, 10, "refetch_ack");
        repeat (10) tick();
        check("refetch_once", ack_cnt, 20);
        rd(1'b1, 16'h0001);
        rd(1'b0, 16'h0003);
        check("refetch_digits", {16'h0, digits}, 32'h0003);

        tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_fifo_reader.md
# keypad_fifo_reader

Hardware initiator for the keypad's status/data/ack interface. It polls the keypad, fetches and acknowledges each key code, and buffers the codes in a small FIFO. The CPU reads the FIFO through a memory-mapped status/data pair, and the last four keys are kept as a 16-bit digit word for the seven-segment driver. It sits between the keypad and the CPU data-input multiplexer, so the CPU no longer drives the keypad handshake itself.

## Interface
- DEPTH, 4: FIFO depth in 4-bit key codes; power of two, 2..16.
- CW, 3: count width; must equal log2(DEPTH)+1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- kp_statusordata  out  1  1 selects keypad status on kp_keyout; 0 selects the key code.
- kp_ack  out  1  one-cycle pulse that consumes the key currently presented by the keypad.
- kp_keyout  in  4  keypad return; in status mode bit0=1 means a key is available.
- cpu_sel  in  1  0 selects the DATA register, 1 selects the STATUS register.
- cpu_rd  in  1  read strobe, one cycle per access; side effects happen at that clock edge.
- cpu_rdata  out  16  combinational read data for the register chosen by cpu_sel.
- digits  out  16  last four keys, newest in [3:0]; feeds sevensegment datain.

## Operation
- FSM states: POLL, FETCH, SETTLE. Reset state is POLL.
- POLL:
  - kp_statusordata=1, kp_ack=0.
  - If kp_keyout[0]=1 and count<DEPTH, go to FETCH. Otherwise stay in POLL.
  - When the FIFO is full, the key stays pending in the keypad and nothing is dropped.
- FETCH:
  - kp_statusordata=0 and kp_ack=1 for exactly this one cycle.
  - kp_keyout is written to FIFO[wptr]; wptr wraps modulo DEPTH; count+1.
  - digits <= {digits[11:0], kp_keyout}.
  - Go to SETTLE.
- SETTLE:
  - kp_statusordata=1, kp_ack=0. Status is ignored for this cycle so the keypad can clear it.
  - Go to POLL.
- STATUS register value: {8'h00, underflow, 2'b00, count[4:0] zero-extended from CW bits}.
  - Note: bit7 = underflow, bits[4:0] = count.
  - With DEPTH<=16, count always fits in [4:0].
- DATA register value: {12'h000, FIFO[rptr]} when count>0; 16'h0000 when empty.
- Pop: cpu_rd=1 with cpu_sel=0 and count>0 advances rptr (wraps modulo DEPTH) and decrements count.
- Read on empty: cpu_rd=1 with cpu_sel=0 and count=0 does not pop and sets the sticky underflow bit.
- Clearing underflow: cpu_rd=1 with cpu_sel=1 returns the current value, then clears underflow at that edge.
- Simultaneous push (FETCH) and pop in the same cycle:
  - Both happen; count is unchanged.
  - This is legal even at count=DEPTH-1.
  - At count=DEPTH a push cannot occur, because FETCH is only entered when count<DEPTH.
- A full FIFO combined with a pop in POLL: the full decision uses the pre-edge count, so the FSM stays in POLL for that cycle and fetches on the next cycle.
- Pointer and count arithmetic: wptr and rptr are log2(DEPTH) bits and wrap naturally; count is CW bits, range 0..DEPTH.

## Timing
- Reset values:
  - State POLL, kp_statusordata=1, kp_ack=0.
  - wptr=rptr=count=0, underflow=0, digits=16'h0000.
  - cpu_rdata follows the rule for an empty FIFO.
- Asynchronous reset mid-FETCH: kp_ack drops immediately and the in-flight key is not pushed. The keypad still holds it, so it is re-fetched after reset.
- Key latency: status seen in POLL at cycle n; ack and push at cycle n+1; count and digits visible at n+2.
- Minimum spacing between acks is 3 cycles (POLL, FETCH, SETTLE).
- kp_ack is never high in two consecutive cycles.
- kp_ack is never high while kp_statusordata=1.
- cpu_rdata is combinational from cpu_sel, the FIFO and count; it carries no registered latency.
- A pop takes effect at the same edge as cpu_rd.

## Test plan
- Single key: keypad status=1 with code 4'h7 for one poll. Expect:
  - kp_ack high for exactly one cycle, with kp_statusordata=0 in that cycle.
  - STATUS then reads 16'h0001 and DATA reads 16'h0007; after the pop, STATUS reads 16'h0000.
  - digits = 16'h0007.
- Fill and backpressure: with DEPTH=4, offer keys 1,2,3,4,5 back to back. Expect:
  - Exactly 4 acks; count=4.
  - Key 5 is not acked until one DATA read, then it is acked within 3 cycles.
  - Pops return 1,2,3,4,5 in order.
  - digits = 16'h2345 after the fifth push.
- Wrap-around: 10 push/pop pairs with codes 0..9. Expect every read to return the matching code and the pointers to wrap without loss.
- Underflow: DATA read on an empty FIFO. Expect:
  - Returns 16'h0000 and STATUS reads 16'h0080.
  - A second STATUS read returns 16'h0000.
  - count stays 0.
- Simultaneous push and pop: at count=2, assert cpu_rd with cpu_sel=0 in the FETCH cycle. Expect count to remain 2 and the head code to advance.
- Reset mid-FETCH: drop rst_n during kp_ack=1. Expect:
  - kp_ack=0 immediately and count=0.
  - After release, the same pending key is fetched again exactly once.
